mult_controller_seq: RTL and testbench

MULT_CONTROLLER_SEQ -- requirements
Module: mult_controller

---
 rtl/mult_controller_seq.sv | 136 +++++++++++++
 tb/tb_mult_controller_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mult_controller_seq.sv
// -----------------------------------------------------------------------------
// mult_controller_seq
//   Sequential radix-2 Booth multiplier for signed two's-complement operands.
//   A request is taken in IDLE, WIDTH Booth steps run in CALC, and the full
//   2*WIDTH-bit product is registered on the way into DONE, where a one-cycle
//   done pulse is issued before returning to IDLE.
//
// Parameters
//   WIDTH         operand width in bits (>= 2)
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         request pulse, sampled only in IDLE
//   multiplicand  signed operand A, captured when a request is accepted
//   multiplier    signed operand B, captured when a request is accepted
//   product       signed A*B, registered, held until the next completion
//   done          one-cycle completion pulse, registered
// -----------------------------------------------------------------------------
module mult_controller_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic [2*WIDTH-1:0]   product,
   output logic                 done
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t               state_q,   state_d;
   logic [WIDTH-1:0]     mcand_q,   mcand_d;
   logic [WIDTH:0]       acc_q,     acc_d;
   logic [WIDTH-1:0]     mplr_q,    mplr_d;
   logic                 qm1_q,     qm1_d;
   logic [CW-1:0]        cnt_q,     cnt_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic                 done_q,    done_d;

   // Sign-extended multiplicand and the add/subtract result of one Booth step
   logic [WIDTH:0]       mcand_ext;
   logic [WIDTH:0]       sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         acc_q     <= '0;
         mplr_q    <= '0;
         qm1_q     <= 1'b0;
         cnt_q     <= '0;
         product_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         mplr_q    <= mplr_d;
         qm1_q     <= qm1_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      mplr_d    = mplr_q;
      qm1_d     = qm1_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      done_d    = 1'b0;

      mcand_ext = {mcand_q[WIDTH-1], mcand_q};

      // Booth recoding of {q0, q-1}: 01 adds A, 10 subtracts A, else no-op.
      // The extra accumulator bit keeps -2^(WIDTH-1) negation exact.
      unique case ({mplr_q[0], qm1_q})
         2'b01:   sum = acc_q + mcand_ext;
         2'b10:   sum = acc_q - mcand_ext;
         default: sum = acc_q;
      endcase

      unique case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d = multiplicand;
               mplr_d  = multiplier;
               acc_d   = '0;
               qm1_d   = 1'b0;
               cnt_d   = CW'(WIDTH);
               state_d = CALC;
            end
         end

         CALC: begin
            if (cnt_q != '0) begin
               // Arithmetic right shift of {sum, Q, q-1}
               acc_d  = {sum[WIDTH], sum[WIDTH:1]};
               mplr_d = {sum[0], mplr_q[WIDTH-1:1]};
               qm1_d  = mplr_q[0];
               cnt_d  = cnt_q - 1'b1;
            end else begin
               // After WIDTH steps {acc[WIDTH-1:0], Q} is the exact product;
               // acc[WIDTH] is only a redundant sign copy at this point.
               product_d = {acc_q[WIDTH-1:0], mplr_q};
               done_d    = 1'b1;
               state_d   = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign product = product_q;
   assign done    = done_q;

endmodule

// File: tb/tb_mult_controller_seq.sv
module tb_mult_controller_seq;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned LAT   = WIDTH + 1;   // accept edge -> done visible

   logic                 clk;
   logic                 rst_n;
   logic                 start;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic [2*WIDTH-1:0]   product;
   logic                 done;

   int n_cmp;
   int n_err;
   logic [2*WIDTH-1:0] last_result;

   mult_controller_seq #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .product      (product),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain signed multiplication, truncated to the output width
   function automatic logic [2*WIDTH-1:0] ref_mul(input int a, input int b);
      int p;
      p = a * b;
      return p[2*WIDTH-1:0];
   endfunction

   // Called at a negedge while the DUT is in IDLE. Raises start immediately so
   // the very next rising edge accepts it. With glitch set, a second start with
   // different operands is pulsed mid-calculation and must be ignored.
   task automatic run_op(input int a, input int b, input bit glitch);
      int  edges;
      bit  got;
      logic [2*WIDTH-1:0] exp;
      exp          = ref_mul(a, b);
      multiplicand = a[WIDTH-1:0];
      multiplier   = b[WIDTH-1:0];
      start        = 1'b1;
      @(posedge clk);                        // accepting edge
      #1;
      start        = 1'b0;
      multiplicand = WIDTH'($urandom);       // later changes must not matter
      multiplier   = WIDTH'($urandom);
      edges = 0;
      got   = 1'b0;
      while (!got && edges < 100) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
         end else begin
            check("hold", 32'(product), 32'(last_result));
            if (glitch && edges == 3) begin
               multiplicand = WIDTH'($urandom);
               multiplier   = WIDTH'($urandom);
               start        = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            edges++;
         end
      end
      check("done_seen", 32'(got), 32'd1);
      check("latency", 32'(edges), 32'(LAT));
      check($sformatf("prod %0d*%0d", a, b), 32'(product), 32'(exp));
      last_result = exp;
      @(negedge clk);
      check("done_pulse_width", 32'(done), 32'd0);
      check("prod_after_done", 32'(product), 32'(exp));
   endtask

   initial begin
      int pairs [12][2] = '{
         '{5, 3}, '{15, 10}, '{0, 5}, '{42, 1},
         '{-5, 3}, '{5, -3}, '{-7, -8},
         '{127, 127}, '{-128, -128}, '{127, -128}, '{-128, -1}, '{-128, 2}
      };
      int dcount;
      n_cmp        = 0;
      n_err        = 0;
      last_result  = '0;
      rst_n        = 1'b0;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("reset_product", 32'(product), 32'd0);
      check("reset_done", 32'(done), 32'd0);

      // Directed values, back-to-back; the first op runs right after reset release
      foreach (pairs[i]) run_op(pairs[i][0], pairs[i][1], 1'b0);

      // Start pulsed during CALC with other operands must be ignored
      run_op(-100, 77, 1'b1);
      run_op(13, -11, 1'b1);

      // Reset in the middle of a calculation
      multiplicand = 8'd9;
      multiplier   = 8'd9;
      start        = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset_product", 32'(product), 32'd0);
      check("midreset_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dcount = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) dcount++;
      end
      check("no_done_after_abort", 32'(dcount), 32'd0);
      check("product_after_abort", 32'(product), 32'd0);
      last_result = '0;

      // Random signed pairs
      for (int k = 0; k < 10; k++) begin
         int a;
         int b;
         a = int'($urandom_range(255)) - 128;
         b = int'($urandom_range(255)) - 128;
         run_op(a, b, k[0]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation timeout");
   end

endmodule
